// File: rtl/cw305_ml_pkg.sv
// Shared types and helpers for the CW305 binarized perceptron layer
// (sequencer and register block).
package cw305_ml_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        ACT,
        DONE
    } ml_state_e;

    localparam int ML_INPUTCNT_DEF  = 4;
    localparam int ML_OUTPUTCNT_DEF = 4;
    localparam int ML_BIASW_DEF     = 4;

    // Wide enough for +/-inputcnt plus any bias, so the sum can never wrap.
    function automatic int ml_acc_width(input int inputcnt, input int biasw);
        int cnt_w;
        cnt_w = $clog2(inputcnt + 1) + 1;
        return ((biasw > cnt_w) ? biasw : cnt_w) + 1;
    endfunction

    function automatic int ml_weight_idx(input int neuron, input int inp, input int inputcnt);
        return neuron * inputcnt + inp;
    endfunction

endpackage

// File: rtl/cw305_ml_mac.sv
// Signed +1/-1/0 accumulator with clear, and a bias-add / sign activation
// that is evaluated combinationally on the current accumulator value.
module cw305_ml_mac
    import cw305_ml_pkg::*;
#(
    parameter int pINPUTCNT = ML_INPUTCNT_DEF,
    parameter int pBIASW    = ML_BIASW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     step,
    input  logic                     in_bit,
    input  logic                     w_bit,
    input  logic signed [pBIASW-1:0] bias,
    output logic                     act_out
);

    localparam int A = ml_acc_width(pINPUTCNT, pBIASW);

    logic signed [A-1:0] acc;
    logic signed [A-1:0] term;
    logic signed [A-1:0] sum;

    // A zero input contributes nothing; otherwise the weight selects +1 or -1.
    always_comb begin
        term = '0;
        if (in_bit) begin
            term = w_bit ? {{(A-1){1'b0}}, 1'b1} : '1;
        end
    end

    assign sum     = acc + A'(bias);
    assign act_out = ~sum[A-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc + term;
        end
    end

endmodule

// File: rtl/cw305_ml_sequencer.sv
// Sequencer for the CW305 binarized perceptron layer: snapshots operands,
// runs one product per clock, applies bias + sign per neuron.
// Optional build macro CW305_ML_TRIGGER_EN enables the registered capture trigger.
module cw305_ml_sequencer
    import cw305_ml_pkg::*;
#(
    parameter int pINPUTCNT  = ML_INPUTCNT_DEF,
    parameter int pOUTPUTCNT = ML_OUTPUTCNT_DEF,
    parameter int pBIASW     = ML_BIASW_DEF
) (
    input  logic                           usb_clk,
    input  logic                           resetn,
    input  logic                           I_start,
    input  logic [pINPUTCNT-1:0]           I_inputs,
    input  logic [pINPUTCNT*pOUTPUTCNT-1:0] I_weights,
    input  logic [pOUTPUTCNT*pBIASW-1:0]   I_bias,
    output logic [pOUTPUTCNT-1:0]          O_outputs,
    output logic                           O_busy,
    output logic                           O_done,
    output logic                           O_trigger
);

    localparam int IW = (pINPUTCNT > 1) ? $clog2(pINPUTCNT) : 1;
    localparam int JW = (pOUTPUTCNT > 1) ? $clog2(pOUTPUTCNT) : 1;
    localparam int WW = pINPUTCNT * pOUTPUTCNT;
    localparam int BW = pOUTPUTCNT * pBIASW;

    ml_state_e state, state_nxt;

    logic [IW-1:0]         i_q;
    logic [JW-1:0]         j_q;
    logic [pINPUTCNT-1:0]  in_sh;
    logic [WW-1:0]         w_sh;
    logic [BW-1:0]         b_sh;
    logic [pOUTPUTCNT-1:0] res_q;
    logic [pOUTPUTCNT-1:0] res_nxt;
    logic [pOUTPUTCNT-1:0] out_q;

    logic                     last_i;
    logic                     last_j;
    logic                     in_bit;
    logic                     w_bit;
    logic signed [pBIASW-1:0] bias_j;
    logic                     mac_clr;
    logic                     mac_step;
    logic                     act_out;

    assign last_i = (i_q == IW'(pINPUTCNT - 1));
    assign last_j = (j_q == JW'(pOUTPUTCNT - 1));

    // Operand selection by shifting keeps the index widths independent of the counters.
    assign in_bit = 1'(in_sh >> i_q);
    assign w_bit  = 1'(w_sh >> ml_weight_idx(int'(j_q), int'(i_q), pINPUTCNT));
    assign bias_j = pBIASW'(b_sh >> (int'(j_q) * pBIASW));

    assign res_nxt = (res_q & ~(pOUTPUTCNT'(1) << j_q)) | (pOUTPUTCNT'(act_out) << j_q);

    always_comb begin
        state_nxt = state;
        mac_clr   = 1'b0;
        mac_step  = 1'b0;
        case (state)
            IDLE: if (I_start) state_nxt = LOAD;
            LOAD: begin
                mac_clr   = 1'b1;
                state_nxt = MAC;
            end
            MAC: begin
                mac_step = 1'b1;
                if (last_i) state_nxt = ACT;
            end
            ACT: begin
                mac_clr   = 1'b1;
                state_nxt = last_j ? DONE : MAC;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shadow operands, counters and result; O_outputs only changes on entry to DONE.
    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            in_sh <= '0;
            w_sh  <= '0;
            b_sh  <= '0;
            i_q   <= '0;
            j_q   <= '0;
            res_q <= '0;
            out_q <= '0;
        end else begin
            case (state)
                LOAD: begin
                    in_sh <= I_inputs;
                    w_sh  <= I_weights;
                    b_sh  <= I_bias;
                    i_q   <= '0;
                    j_q   <= '0;
                    res_q <= '0;
                end
                MAC: i_q <= i_q + IW'(1);
                ACT: begin
                    i_q   <= '0;
                    res_q <= res_nxt;
                    if (last_j) begin
                        out_q <= res_nxt;
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    cw305_ml_mac #(
        .pINPUTCNT (pINPUTCNT),
        .pBIASW    (pBIASW)
    ) u_mac (
        .clk     (usb_clk),
        .rst_n   (resetn),
        .clr     (mac_clr),
        .step    (mac_step),
        .in_bit  (in_bit),
        .w_bit   (w_bit),
        .bias    (bias_j),
        .act_out (act_out)
    );

`ifdef CW305_ML_TRIGGER_EN
    logic trig_q;

    // High from the first MAC through the last ACT of the run.
    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            trig_q <= 1'b0;
        end else if (state == LOAD) begin
            trig_q <= 1'b1;
        end else if (state == ACT && last_j) begin
            trig_q <= 1'b0;
        end
    end

    assign O_trigger = trig_q;
`else
    assign O_trigger = 1'b0;
`endif

    assign O_busy    = (state != IDLE);
    assign O_done    = (state == DONE);
    assign O_outputs = out_q;

endmodule

// File: tb/tb_cw305_ml_sequencer.sv
// Scoreboard bench for cw305_ml_sequencer at default parameters.
module tb_cw305_ml_sequencer;

    logic        usb_clk = 1'b0;
    logic        resetn;
    logic        I_start;
    logic [3:0]  I_inputs;
    logic [15:0] I_weights;
    logic [15:0] I_bias;
    logic [3:0]  O_outputs;
    logic        O_busy;
    logic        O_done;
    logic        O_trigger;

    cw305_ml_sequencer dut (
        .usb_clk   (usb_clk),
        .resetn    (resetn),
        .I_start   (I_start),
        .I_inputs  (I_inputs),
        .I_weights (I_weights),
        .I_bias    (I_bias),
        .O_outputs (O_outputs),
        .O_busy    (O_busy),
        .O_done    (O_done),
        .O_trigger (O_trigger)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct {
        logic [3:0] outs;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   e0 = 0;
    bit   run_active = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge usb_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Called just after a negedge; start is sampled on the next posedge (cycle 0).
    task automatic start_run(input logic [3:0] inp, input logic [15:0] w,
                             input logic [15:0] b, input logic [3:0] expect_out);
        exp_t e;
        I_inputs   = inp;
        I_weights  = w;
        I_bias     = b;
        I_start    = 1'b1;
        e0         = cyc + 1;
        run_active = 1'b1;
        e.outs     = expect_out;
        e.cyc      = e0 + 21;
        q.push_back(e);
        @(negedge usb_clk);
        I_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (O_busy && n < 100) begin
            @(negedge usb_clk);
            n++;
        end
        chk("idle_timeout", int'(n < 100), 1);
    endtask

    // Monitor: every cycle checks busy/trigger windows, and pops on O_done.
    initial begin
        exp_t e;
        bit   exp_busy;
        bit   exp_trig;
        forever begin
            @(posedge usb_clk);
            #1;
            exp_busy = run_active && cyc >= e0 && cyc <= e0 + 21;
`ifdef CW305_ML_TRIGGER_EN
            exp_trig = run_active && cyc >= e0 + 1 && cyc <= e0 + 20;
`else
            exp_trig = 1'b0;
`endif
            chk("busy", int'(O_busy), int'(exp_busy));
            chk("trigger", int'(O_trigger), int'(exp_trig));
            if (O_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("outputs", int'(O_outputs), int'(e.outs));
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        I_start   = 1'b0;
        I_inputs  = '0;
        I_weights = '0;
        I_bias    = '0;
        repeat (2) @(negedge usb_clk);
        chk("rst_outputs", int'(O_outputs), 0);
        chk("rst_busy", int'(O_busy), 0);
        chk("rst_done", int'(O_done), 0);
        chk("rst_trigger", int'(O_trigger), 0);
        resetn = 1'b1;
        @(negedge usb_clk);

        start_run(4'b0001, 16'hFFFF, 16'h0000, 4'b1111);
        wait_idle();
        start_run(4'b0001, 16'h0000, 16'h0000, 4'b0000);
        wait_idle();
        start_run(4'b1111, 16'h000F, 16'h4000, 4'b1001);
        wait_idle();
        start_run(4'b0000, 16'h1234, 16'hF0F0, 4'b0101);
        wait_idle();
        start_run(4'b0110, 16'h0F63, 16'h1000, 4'b0111);
        wait_idle();

        // Operand change and second start mid-run must not disturb the run.
        start_run(4'b0001, 16'hFFFF, 16'h0000, 4'b1111);
        repeat (4) @(negedge usb_clk);
        I_weights = 16'h0000;
        I_start   = 1'b1;
        @(negedge usb_clk);
        I_start = 1'b0;
        chk("busy_after_restart", int'(O_busy), 1);
        wait_idle();

        // Asynchronous abort at cycle 10 with nonzero outputs held from before.
        start_run(4'b0001, 16'h0000, 16'h0000, 4'b0000);
        repeat (9) @(negedge usb_clk);
        run_active = 1'b0;
        q.delete();
        resetn = 1'b0;
        #1;
        chk("abort_busy", int'(O_busy), 0);
        chk("abort_outputs", int'(O_outputs), 0);
        chk("abort_done", int'(O_done), 0);
        chk("abort_trigger", int'(O_trigger), 0);
        @(negedge usb_clk);
        resetn = 1'b1;
        @(negedge usb_clk);

        start_run(4'b0110, 16'h0F63, 16'h1000, 4'b0111);
        wait_idle();
        repeat (3) @(negedge usb_clk);
        chk("pending_expectations", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
